// File: rtl/qdec_ctx_init.sv
// qdec_ctx_init: CABAC context initialisation engine (initValue ROM -> context memory).
// Define QDEC_CTX_INIT_VERIFY_EN to add a read-back verification pass after each init run.
module qdec_ctx_init #(
  parameter int NUM_CTX = 186,
  parameter int CTX_AW  = 10,
  parameter int ROM_AW  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        slice_qp,
  input  logic [1:0]        init_type,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] init_rom_addr,
  input  logic [7:0]        init_rom_data,
  output logic [CTX_AW-1:0] ctx_addr,
  output logic [7:0]        ctx_wdata,
  output logic              ctx_we,
  output logic              ctx_re,
  input  logic [7:0]        ctx_rdata,
  output logic              verify_err
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, VERIFY} state_t;
  state_t state_q, state_d;
  logic [CTX_AW-1:0] idx_q, idx1_q, ctx_addr_q;
  logic [7:0] ctx_wdata_q, exp_state;
  logic [6:0] qp_q;
  logic [5:0] qpc;
  logic [1:0] type_q;
  logic dcnt_q, v1_q, ctx_we_q, last_idx, walking;

  function automatic logic [7:0] calc_state(input logic [7:0] iv, input logic [5:0] qc);
    logic signed [7:0] m, n;
    logic signed [13:0] p, s;
    logic [6:0] pre;
    m = $signed({4'b0, iv[7:4]}) * 8'sd5 - 8'sd45;
    n = $signed({1'b0, iv[3:0], 3'b0}) - 8'sd16;
    p = $signed({{6{m[7]}}, m}) * $signed({8'b0, qc});
    s = (p >>> 4) + $signed({{6{n[7]}}, n});
    pre = s < 14'sd1 ? 7'd1 : s > 14'sd126 ? 7'd126 : s[6:0];
    return pre > 7'd63 ? {1'b0, 6'(pre - 7'd64), 1'b1} : {1'b0, 6'(7'd63 - pre), 1'b0};
  endfunction

  assign last_idx  = idx_q == CTX_AW'(NUM_CTX - 1);
  assign walking   = state_q == RUN || state_q == VERIFY;
  assign qpc       = qp_q[6] ? 6'd0 : qp_q > 7'd51 ? 6'd51 : qp_q[5:0];
  assign exp_state = calc_state(init_rom_data, qpc);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

`ifdef QDEC_CTX_INIT_VERIFY_EN
  logic vv_q, vpass_q, err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      vv_q    <= 1'b0;
      vpass_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vv_q <= state_q == VERIFY;
      if (state_q == IDLE && start) begin
        vpass_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (state_q == DONE) vpass_q <= 1'b1;
        if (vv_q && ctx_rdata != exp_state) err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^ctx_rdata;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = start ? RUN : IDLE;
      RUN:    state_d = last_idx ? DRAIN : RUN;
      DRAIN:  state_d = dcnt_q ? DONE : DRAIN;
`ifdef QDEC_CTX_INIT_VERIFY_EN
      DONE:   state_d = vpass_q ? IDLE : VERIFY;
      VERIFY: state_d = last_idx ? DRAIN : VERIFY;
`else
      DONE:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = state_q != IDLE;
    done          = state_q == DONE;
    init_rom_addr = walking ? ROM_AW'(type_q) * ROM_AW'(NUM_CTX) + ROM_AW'(idx_q) : '0;
`ifdef QDEC_CTX_INIT_VERIFY_EN
    ctx_re        = state_q == VERIFY;
    verify_err    = err_q;
`else
    ctx_re        = 1'b0;
    verify_err    = 1'b0;
`endif
    ctx_addr      = ctx_re ? idx_q : ctx_addr_q;
    ctx_we        = ctx_we_q;
    ctx_wdata     = ctx_wdata_q;
  end

  // ROM data for idx_q arrives one cycle later, so the index rides along in idx1_q
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      idx1_q      <= '0;
      dcnt_q      <= 1'b0;
      qp_q        <= '0;
      type_q      <= '0;
      v1_q        <= 1'b0;
      ctx_we_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_wdata_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        qp_q   <= slice_qp;
        type_q <= init_type == 2'd3 ? 2'd2 : init_type;
      end
      idx_q    <= walking && !last_idx ? idx_q + 1'b1 : '0;
      dcnt_q   <= state_q == DRAIN && !dcnt_q;
      v1_q     <= state_q == RUN;
      idx1_q   <= idx_q;
      ctx_we_q <= v1_q;
      if (v1_q) begin
        ctx_addr_q  <= idx1_q;
        ctx_wdata_q <= exp_state;
      end
    end
  end
endmodule

// File: tb/tb_qdec_ctx_init.sv
// tb_qdec_ctx_init: scoreboard bench for qdec_ctx_init with ROM/context-memory models.
module tb_qdec_ctx_init;
  localparam int N = 186;
`ifdef QDEC_CTX_INIT_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  typedef struct {int addr; int data;} wr_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] slice_qp = '0;
  logic [1:0] init_type = '0;
  logic busy, done, ctx_we, ctx_re, verify_err;
  logic [9:0] init_rom_addr, ctx_addr;
  logic [7:0] init_rom_data = '0, ctx_rdata = '0, ctx_wdata;
  logic [7:0] rom [1024];
  logic [7:0] mem [N];
  logic [7:0] snap [N];
  int checks = 0, errors = 0, cyc = 0, s_cyc = 0, done_n = 0;
  int amin, amax, acnt;
  bit first_seen = 0, corrupt_en = 0, corrupt_now = 0;
  wr_t q[$];
  wr_t e;

  qdec_ctx_init dut (
    .clk(clk), .rst(rst), .start(start), .slice_qp(slice_qp), .init_type(init_type),
    .busy(busy), .done(done), .init_rom_addr(init_rom_addr), .init_rom_data(init_rom_data),
    .ctx_addr(ctx_addr), .ctx_wdata(ctx_wdata), .ctx_we(ctx_we), .ctx_re(ctx_re),
    .ctx_rdata(ctx_rdata), .verify_err(verify_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) init_rom_data <= rom[init_rom_addr];
  always @(posedge clk) begin
    if (ctx_we) mem[ctx_addr] <= ctx_wdata;
    else if (corrupt_now) mem[5] <= mem[5] ^ 8'h10;
    if (ctx_re) ctx_rdata <= mem[ctx_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_state(input int iv, input int qp);
    int qc, m, n, p, t, pre;
    qc  = qp < 0 ? 0 : qp > 51 ? 51 : qp;
    m   = (iv / 16) * 5 - 45;
    n   = (iv % 16) * 8 - 16;
    p   = m * qc;
    t   = p >= 0 ? p / 16 : -((-p + 15) / 16);
    pre = t + n;
    pre = pre < 1 ? 1 : pre > 126 ? 126 : pre;
    return pre > 63 ? (pre - 64) * 2 + 1 : (63 - pre) * 2;
  endfunction

  always @(negedge clk) begin
    corrupt_now = 0;
    if (!rst) begin
      if (ctx_we) begin
        if (q.size() == 0) chk("unexpected_we", ctx_we, 0);
        else begin
          e = q.pop_front();
          chk("we_addr", ctx_addr, e.addr);
          chk("we_data", ctx_wdata, e.data);
          chk("we_cycle", cyc - s_cyc, 3 + e.addr);
          chk("busy_we", busy, 1);
        end
      end
      if (init_rom_addr != 0) begin
        amin = init_rom_addr < amin ? init_rom_addr : amin;
        amax = init_rom_addr > amax ? init_rom_addr : amax;
        acnt++;
      end
      if (done) begin
        done_n++;
        chk("busy_with_done", busy, 1);
        if (!first_seen) begin
          first_seen  = 1;
          chk("done_cycle", cyc - s_cyc, N + 3);
          corrupt_now = corrupt_en;
        end
      end
`ifndef QDEC_CTX_INIT_VERIFY_EN
      chk("ctx_re_zero", ctx_re, 0);
      chk("verify_err_zero", verify_err, 0);
`endif
    end
  end

  task automatic run(input int ty, input int qp, input bit extra);
    int t2, k, tgt;
    t2 = ty == 3 ? 2 : ty;
    k  = 0;
    for (int i = 0; i < N; i++) q.push_back('{i, ref_state(rom[t2 * N + i], qp)});
    amin = 1 << 30; amax = 0; acnt = 0; first_seen = 0; tgt = done_n + PASSES;
    @(posedge clk); #1;
    start = 1; slice_qp = 7'(qp); init_type = 2'(ty); s_cyc = cyc;
    @(posedge clk); #1;
    start = 0; slice_qp = 7'($urandom); init_type = 2'($urandom);
    while (done_n < tgt && k < 1000) begin
      @(posedge clk); #1;
      k++;
      start = extra && cyc == s_cyc + 50;
    end
    chk("run_done_count", done_n, tgt);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("queue_empty", q.size(), 0);
    chk("verify_err_end", verify_err, int'(corrupt_en));
    q.delete();
  endtask

  task automatic chk_range(input string name);
    chk({name, "_min"}, amin, 2 * N);
    chk({name, "_max"}, amax, 3 * N - 1);
    chk({name, "_cnt"}, acnt, N * PASSES);
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int b = 0; b < 3; b++) begin
      rom[b * N] = 8'd154; rom[b * N + 1] = 8'd139; rom[b * N + 2] = 8'd0; rom[b * N + 3] = 8'd255;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_we", ctx_we, 0);
    chk("rst_re", ctx_re, 0); chk("rst_rom_addr", init_rom_addr, 0); chk("rst_ctx_addr", ctx_addr, 0);
    chk("rst_wdata", ctx_wdata, 0); chk("rst_verr", verify_err, 0);
    @(posedge clk); #1 rst = 0;
    run(0, 26, 0);
    chk("iv154_qp26", mem[0], 8'h01);
    chk("iv139_qp26", mem[1], 8'h00);
    run(1, 0, 0);
    chk("iv0_qp0", mem[2], 8'h7C);
    snap = mem;
    run(1, -12, 0);
    diffs = 0;
    for (int i = 0; i < N; i++) diffs += int'(mem[i] != snap[i]);
    chk("qp_neg_eq_zero", diffs, 0);
    run(2, 51, 0);
    chk("iv255_qp51", mem[3], 8'h7D);
    chk_range("type2");
    run(3, $urandom_range(0, 63), 0);
    chk_range("type3");
    run(0, 30, 1);
    for (int r = 0; r < 4; r++) run($urandom_range(0, 3), $urandom_range(0, 127) - 64, 0);
    // abort mid-run with rst, then restart cleanly
    for (int i = 0; i < N; i++) q.push_back('{i, ref_state(rom[i], 20)});
    @(posedge clk); #1;
    start = 1; slice_qp = 7'd20; init_type = 2'd0; s_cyc = cyc;
    @(posedge clk); #1 start = 0;
    repeat (39) @(posedge clk);
    #1 rst = 1; q.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_we", ctx_we, 0);
    repeat (10) @(negedge clk);
    chk("abort_idle_we", ctx_we, 0);
    run(0, 33, 0);
`ifdef QDEC_CTX_INIT_VERIFY_EN
    corrupt_en = 1;
    run(0, 20, 0);
    corrupt_en = 0;
    run(0, 20, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qdec_ctx_init.md
Name: qdec_ctx_init

Overview:
CABAC context initialisation engine. At slice start it walks every context index, reads the 8-bit initValue from an external init-value ROM, and derives the initial probability state from the slice QP. It then writes that state into the context memory over the ctx memory write port. It sits between the slice-header parser (start/QP/init_type) and the context memory. It is the only writer of the context memory outside the bin decoder's state update.

Parameters:
NUM_CTX, 186, number of contexts initialised per slice (indices 0..NUM_CTX-1).
CTX_AW, 10, context memory address width.
ROM_AW, 10, init-value ROM address width; must satisfy 3*NUM_CTX <= 2**ROM_AW.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to initialise; honoured only in IDLE
slice_qp  input  7  SliceQpY, signed two's complement
init_type  input  2  table select 0/1/2; value 3 is treated as 2
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when all contexts have been written
init_rom_addr  output  ROM_AW  = init_type*NUM_CTX + idx
init_rom_data  input  8  initValue, valid one cycle after init_rom_addr
ctx_addr  output  CTX_AW  context index
ctx_wdata  output  8  {1'b0, pStateIdx[5:0], valMps}
ctx_we  output  1  write strobe
ctx_re  output  1  read strobe (verify pass only)
ctx_rdata  input  8  context memory read data, one-cycle latency
verify_err  output  1  sticky mismatch flag (only with feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index counter cleared. Reset mid-run aborts immediately; no further ctx_we is issued.
- FSM states:
  - IDLE: start moves to RUN; slice_qp and init_type are latched.
  - RUN: issues one ROM address per cycle, idx 0..NUM_CTX-1, then moves to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then moves to DONE.
  - DONE: pulses done for 1 cycle, then returns to IDLE (or to VERIFY when the feature is enabled).
- start while busy is ignored. The latched QP and type are stable for the whole run.
- Pipeline: start sampled at cycle 0. init_rom_addr for idx i is driven at cycle 1+i. ROM data returns at 2+i. ctx_addr=i, ctx_wdata and ctx_we are registered at 3+i.
- The last write is at cycle NUM_CTX+2; done is at cycle NUM_CTX+3; busy falls with done.
- ctx_we is high exactly NUM_CTX cycles, contiguous. ctx_re is 0 outside VERIFY.
- Arithmetic, per entry:
  - qpc = Clip3(0,51,slice_qp)
  - slope = initValue[7:4], offset = initValue[3:0]
  - m = slope*5-45, signed, range -45..30
  - n = (offset<<3)-16, range -16..104
  - p = (m*qpc), at least 13-bit signed
  - t = (p >>> 4), arithmetic shift (floor)
  - pre = Clip3(1,126, t+n)
  - valMps = (pre>63)
  - pStateIdx = valMps ? pre-64 : 63-pre
- ctx_wdata[7] is always 0.

Optional Feature:
QDEC_CTX_INIT_VERIFY_EN: after DONE the FSM enters VERIFY instead of IDLE.
- VERIFY re-walks all NUM_CTX indices: it asserts ctx_re with ctx_addr=i and re-fetches the ROM value.
- It recomputes the expected state and compares it with ctx_rdata one cycle later.
- Any mismatch sets verify_err, which stays set until the next accepted start or rst.
- busy stays high through VERIFY. A second done pulse marks the end of verification.
Without the macro: no VERIFY state, ctx_re is tied 0, verify_err is tied 0, and exactly one done pulse per start.

Test Plan:
- initValue=154, qp=26 -> m=0, n=64, pre=64, ctx_wdata=0x01.
- initValue=139, qp=26 -> -130>>>4=-9, pre=63, ctx_wdata=0x00 (checks floor shift).
- initValue=0, qp=0 -> pre clipped to 1, ctx_wdata=0x7C.
- initValue=255, qp=51 -> 95+104=199 clipped to 126, ctx_wdata=0x7D.
- qp=-12 gives the same writes as qp=0.
- init_type=2 with NUM_CTX=186 -> init_rom_addr runs 372..557.
- Full run timing: ctx_we contiguous for 186 cycles, done exactly at cycle 189 after start. A second start at cycle 50 is ignored.
- rst asserted at cycle 40 -> next cycle busy=0, ctx_we=0. A new start then rewrites from idx 0.
- With the VERIFY macro: corrupt one memory entry between the write and verify passes -> verify_err=1. A clean run keeps verify_err=0, with two done pulses.
